// File: rtl/ahb_sim_mailbox_pkg.sv
// rtl/ahb_sim_mailbox_pkg.sv - shared constants, register decode and state codes for the AHB mailbox
package ahb_mbox_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [31:0] OFS_DATA   = 32'd0;
  localparam logic [31:0] OFS_STATUS = 32'd4;
  localparam logic [31:0] OFS_CTRL   = 32'd8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DPHASE = 3'd1;
  localparam logic [2:0] STALL  = 3'd2;
  localparam logic [2:0] ERR1   = 3'd3;
  localparam logic [2:0] ERR2   = 3'd4;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL,
    SEL_NONE
  } mbox_sel_e;

  function automatic mbox_sel_e decode_ofs(input logic [31:0] ofs);
    case (ofs)
      OFS_DATA:   return SEL_DATA;
      OFS_STATUS: return SEL_STATUS;
      OFS_CTRL:   return SEL_CTRL;
      default:    return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] status_word(input logic [7:0] lvl, input logic full,
                                              input logic empty);
    return {16'h0000, 6'b000000, lvl, full, empty};
  endfunction

endpackage

// File: rtl/ahb_sim_mailbox_if.sv
// rtl/ahb_sim_mailbox_if.sv - AHB-Lite slave port plus character output port of the mailbox
interface ahb_sim_mailbox_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        chr_valid;
  logic [7:0]  chr_data;
  logic        chr_ready;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready, chr_ready,
    output hreadyout, hresp, hrdata, chr_valid, chr_data
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready, chr_ready,
    input  hreadyout, hresp, hrdata, chr_valid, chr_data
  );
endinterface

// File: rtl/ahb_sim_mailbox_fifo.sv
// rtl/ahb_sim_mailbox_fifo.sv - synchronous FIFO with flush; flush beats any same-cycle push/pop
module mbox_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      lvl_q;
  logic             do_push, do_pop;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == (AW+1)'(DEPTH));
  assign level   = lvl_q;
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/ahb_sim_mailbox.sv
// rtl/ahb_sim_mailbox.sv - AHB-Lite mailbox: DATA writes feed a character FIFO, DATA reads return a cycle counter
module ahb_sim_mailbox
  import ahb_mbox_pkg::*;
#(
  parameter logic [31:0] MBOX_ADDR  = 32'h2001FFF0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic               sysclk,
  input  logic               sysrst,
  ahb_sim_mailbox_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]  state_q, state_d;
  mbox_sel_e   sel_q, sel_d, sel_in;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [31:0] cnt_q, cnt_d;

  logic        acc, need, ctrl_wr, complete;
  logic        push, pop, flush, cnt_clr;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_level;
  logic [7:0]  fifo_head;

  assign sel_in = decode_ofs(bus.haddr - MBOX_ADDR);
  assign acc    = bus.hsel & bus.hready & bus.htrans[1];

  // need: a DATA write in its data phase whose byte has not yet entered the FIFO.
  assign need     = (state_q == DPHASE) & write_q & (sel_q == SEL_DATA) & ~done_q;
  assign ctrl_wr  = (state_q == DPHASE) & write_q & (sel_q == SEL_CTRL);
  assign pop      = bus.chr_valid & bus.chr_ready;
  assign push     = (need & ~fifo_full) | ((state_q == STALL) & pop);
  assign flush    = ctrl_wr & bus.hwdata[1];
  assign cnt_clr  = ctrl_wr & bus.hwdata[0];
  assign complete = (state_q == IDLE) | (state_q == ERR2) |
                    ((state_q == DPHASE) & ~(need & fifo_full));

  assign bus.hreadyout = ~(((state_q == DPHASE) & need & fifo_full) |
                           (state_q == STALL) | (state_q == ERR1));
  assign bus.hresp     = ((state_q == ERR1) | (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = hrdata_q;
  assign bus.chr_valid = ~fifo_empty;
  assign bus.chr_data  = fifo_head;

  always_comb begin
    cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    if (cnt_clr) cnt_d = 32'd0;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    write_d  = write_q;
    done_d   = done_q;
    hrdata_d = hrdata_q;
    case (state_q)
      ERR1:    state_d = ERR2;
      STALL:   if (pop) begin
                 state_d = DPHASE;
                 done_d  = 1'b1;
               end
      DPHASE:  if (need && fifo_full) state_d = STALL;
      default: ;
    endcase
    if (complete) begin
      if (acc) begin
        state_d = (sel_in == SEL_NONE) ? ERR1 : DPHASE;
        sel_d   = sel_in;
        write_d = bus.hwrite;
        done_d  = 1'b0;
        if (bus.hwrite || sel_in == SEL_NONE || sel_in == SEL_CTRL) hrdata_d = 32'd0;
        else if (sel_in == SEL_DATA) hrdata_d = cnt_q;
        else hrdata_d = status_word(8'(fifo_level), fifo_full, fifo_empty);
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state_q  <= IDLE;
      sel_q    <= SEL_NONE;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      hrdata_q <= 32'd0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      write_q  <= write_d;
      done_q   <= done_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  mbox_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sysclk),
    .rst   (sysrst),
    .push  (push),
    .wdata (bus.hwdata[7:0]),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_ahb_sim_mailbox.sv
// tb/tb_ahb_sim_mailbox.sv - directed self-checking bench for ahb_sim_mailbox
module tb_ahb_sim_mailbox;

  localparam logic [31:0] MB = 32'h2001FFF0;

  logic sysclk = 1'b0;
  logic sysrst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ahb_sim_mailbox_if bus ();
  assign bus.hready = bus.hreadyout;

  ahb_sim_mailbox #(.MBOX_ADDR(MB), .FIFO_DEPTH(16)) dut (
    .sysclk (sysclk),
    .sysrst (sysrst),
    .bus    (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge on which the data phase completes.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits, output logic [1:0] resp,
                      output logic [1:0] resp1, output logic rdy1);
    bus.hsel   = 1'b1;
    bus.haddr  = addr;
    bus.htrans = 2'b10;
    bus.hwrite = wr;
    @(posedge sysclk);
    @(negedge sysclk);
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwdata = wd;
    rdy1  = bus.hreadyout;
    resp1 = bus.hresp;
    waits = 0;
    while (!bus.hreadyout && waits < 100) begin
      waits++;
      @(negedge sysclk);
    end
    rd   = bus.hrdata;
    resp = bus.hresp;
  endtask

  logic [31:0] r1, r2, rd;
  logic [1:0]  resp, resp1;
  logic        rdy1;
  int          waits;

  initial begin
    bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
    bus.hsize = 3'b010; bus.hwdata = '0; bus.chr_ready = 1'b0;
    repeat (2) @(negedge sysclk);
    chk("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    chk("rst_hresp", 32'(bus.hresp), 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_chr_valid", 32'(bus.chr_valid), 32'd0);
    chk("rst_chr_data", 32'(bus.chr_data), 32'd0);
    sysrst = 1'b0;

    // Cycle counter: accept edge is the 11th edge after release, then the 16th.
    repeat (10) @(negedge sysclk);
    xfer(MB, 1'b0, 0, r1, waits, resp, resp1, rdy1);
    chk("cnt_first", r1, 32'd10);
    chk("cnt_first_waits", 32'(waits), 32'd0);
    repeat (4) @(negedge sysclk);
    xfer(MB, 1'b0, 0, r2, waits, resp, resp1, rdy1);
    chk("cnt_delta", r2 - r1, 32'd5);

    // Two characters drained with the consumer ready.
    bus.chr_ready = 1'b1;
    xfer(MB, 1'b1, 32'h48, rd, waits, resp, resp1, rdy1);
    chk("wr_h_waits", 32'(waits), 32'd0);
    @(negedge sysclk);
    chk("chr_h_valid", 32'(bus.chr_valid), 32'd1);
    chk("chr_h_data", 32'(bus.chr_data), 32'h48);
    xfer(MB, 1'b1, 32'h69, rd, waits, resp, resp1, rdy1);
    chk("wr_i_waits", 32'(waits), 32'd0);
    @(negedge sysclk);
    chk("chr_i_data", 32'(bus.chr_data), 32'h69);
    @(negedge sysclk);
    bus.chr_ready = 1'b0;
    chk("drained", 32'(bus.chr_valid), 32'd0);

    // Fill to 16, then stall the 17th write until one pop.
    for (int i = 0; i < 16; i++) begin
      xfer(MB, 1'b1, 32'h41 + 32'(i), rd, waits, resp, resp1, rdy1);
      chk("fill_waits", 32'(waits), 32'd0);
    end
    @(negedge sysclk);
    xfer(MB + 4, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("status_full", rd, 32'h42);
    bus.hsel = 1'b1; bus.haddr = MB; bus.htrans = 2'b10; bus.hwrite = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'h5A;
    chk("stall_rdy0", 32'(bus.hreadyout), 32'd0);
    repeat (3) @(negedge sysclk);
    chk("stall_rdy_held", 32'(bus.hreadyout), 32'd0);
    chk("stall_head", 32'(bus.chr_data), 32'h41);
    bus.chr_ready = 1'b1;
    @(negedge sysclk);
    bus.chr_ready = 1'b0;
    chk("stall_release", 32'(bus.hreadyout), 32'd1);
    chk("stall_new_head", 32'(bus.chr_data), 32'h42);
    xfer(MB + 4, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("status_still_full", rd, 32'h42);

    // Flush, then error accesses at offset 0xC.
    xfer(MB + 8, 1'b1, 32'h2, rd, waits, resp, resp1, rdy1);
    @(negedge sysclk);
    chk("flush_valid", 32'(bus.chr_valid), 32'd0);
    xfer(MB + 12, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("err_rd_rdy1", 32'(rdy1), 32'd0);
    chk("err_rd_resp1", 32'(resp1), 32'd1);
    chk("err_rd_waits", 32'(waits), 32'd1);
    chk("err_rd_resp2", 32'(resp), 32'd1);
    xfer(MB + 12, 1'b1, 32'h55, rd, waits, resp, resp1, rdy1);
    chk("err_wr_resp2", 32'(resp), 32'd1);
    @(negedge sysclk);
    chk("err_wr_nopush", 32'(bus.chr_valid), 32'd0);
    xfer(MB + 4, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("status_empty", rd, 32'h1);
    chk("status_okay", 32'(resp), 32'd0);

    // Saturation and clear.
    force dut.cnt_q = 32'hFFFF_FFFE;
    @(negedge sysclk);
    release dut.cnt_q;
    repeat (5) @(negedge sysclk);
    xfer(MB, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("cnt_sat", rd, 32'hFFFF_FFFF);
    xfer(MB + 8, 1'b1, 32'h1, rd, waits, resp, resp1, rdy1);
    repeat (4) @(negedge sysclk);
    xfer(MB, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("cnt_clear", rd, 32'd3);

    // Flush coincident with pops.
    for (int i = 0; i < 4; i++) xfer(MB, 1'b1, 32'h31 + 32'(i), rd, waits, resp, resp1, rdy1);
    @(negedge sysclk);
    bus.chr_ready = 1'b1;
    xfer(MB + 8, 1'b1, 32'h2, rd, waits, resp, resp1, rdy1);
    @(negedge sysclk);
    chk("flush_pop_valid", 32'(bus.chr_valid), 32'd0);
    bus.chr_ready = 1'b0;
    xfer(MB + 4, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("flush_pop_status", rd, 32'h1);

    // Reset in the middle of a stall.
    for (int i = 0; i < 16; i++) xfer(MB, 1'b1, 32'h61 + 32'(i), rd, waits, resp, resp1, rdy1);
    bus.hsel = 1'b1; bus.haddr = MB; bus.htrans = 2'b10; bus.hwrite = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'h7A;
    chk("rst_stall_rdy0", 32'(bus.hreadyout), 32'd0);
    sysrst = 1'b1;
    #1;
    chk("rst_stall_rdy", 32'(bus.hreadyout), 32'd1);
    chk("rst_stall_valid", 32'(bus.chr_valid), 32'd0);
    chk("rst_stall_hresp", 32'(bus.hresp), 32'd0);
    @(negedge sysclk);
    sysrst = 1'b0;
    @(negedge sysclk);
    xfer(MB + 4, 1'b0, 0, rd, waits, resp, resp1, rdy1);
    chk("rst_stall_status", rd, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
